// File: rtl/robo_pkg.sv
// Shared types for the parametrised collector robot: one-hot FSM state,
// synchroniser bit positions and the sensor decision rule.
package robo_pkg;

    typedef enum logic [4:0] {
        INICIAL   = 5'b00001,
        AVANCANDO = 5'b00010,
        GIRANDO   = 5'b00100,
        REMOVENDO = 5'b01000,
        STANDBY   = 5'b10000
    } state_e;

    localparam int SENS_W      = 5;
    localparam int IDX_HEAD    = 0;
    localparam int IDX_LEFT    = 1;
    localparam int IDX_UNDER   = 2;
    localparam int IDX_BARRIER = 3;
    localparam int IDX_RESUME  = 4;

    // First match wins: floor loss, garbage, obstacle, lost wall, else drive on.
    function automatic state_e decide(input logic h, input logic l,
                                      input logic u, input logic b);
        if (!u) return STANDBY;
        if (b)  return REMOVENDO;
        if (h)  return GIRANDO;
        if (!l) return GIRANDO;
        return AVANCANDO;
    endfunction

endpackage

// File: rtl/robo_coletor_param_if.sv
// Sensor and motor bundle between the sensor front-end (master) and the
// robot controller (slave).
interface robo_coletor_param_if #(parameter int CNT_W = 8);

    logic             head;
    logic             left;
    logic             under;
    logic             barrier;
    logic             resume;
    logic             forward;
    logic             turn;
    logic             remove;
    logic             stalled;
    logic [CNT_W-1:0] collected;

    modport master (
        output head, left, under, barrier, resume,
        input  forward, turn, remove, stalled, collected
    );

    modport slave (
        input  head, left, under, barrier, resume,
        output forward, turn, remove, stalled, collected
    );

endinterface

// File: rtl/robo_sync.sv
// Multi-stage flop chain bringing asynchronous pad inputs into the clock
// domain; every bit gets STAGES flops and resets to 0.
module robo_sync #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] chain_q [STAGES];
    logic [WIDTH-1:0] chain_d [STAGES];

    always_comb begin
        chain_d[0] = d;
        for (int i = 1; i < STAGES; i++) begin
            chain_d[i] = chain_q[i-1];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples its predecessor's old value and the chain really shifts by one.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < STAGES; i++) begin
                chain_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                chain_q[i] <= chain_d[i];
            end
        end
    end

    assign q = chain_q[STAGES-1];

endmodule

// File: rtl/robo_coletor_param.sv
// Collector robot controller: Moore FSM with timed turn/remove actions,
// stall watchdog, saturating collected counter and resume from standby.
module robo_coletor_param
    import robo_pkg::*;
#(
    parameter int TURN_CYCLES   = 4,
    parameter int REMOVE_CYCLES = 8,
    parameter int STALL_LIMIT   = 16,
    parameter int CNT_W         = 8,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    robo_coletor_param_if.slave  bus
);

    localparam int TMR_MAX = (TURN_CYCLES > REMOVE_CYCLES) ? TURN_CYCLES : REMOVE_CYCLES;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam int STALL_W = $clog2(STALL_LIMIT + 1);
    localparam int FILL_W  = $clog2(SYNC_STAGES + 1);

    localparam logic [TMR_W-1:0]   TURN_LOAD   = TMR_W'(TURN_CYCLES - 1);
    localparam logic [TMR_W-1:0]   REMOVE_LOAD = TMR_W'(REMOVE_CYCLES - 1);
    localparam logic [STALL_W-1:0] STALL_MAX   = STALL_W'(STALL_LIMIT);
    localparam logic [FILL_W-1:0]  FILL_DONE   = FILL_W'(SYNC_STAGES);
    localparam logic [CNT_W-1:0]   CNT_MAX     = '1;

    logic [SENS_W-1:0] pads;
    logic [SENS_W-1:0] sens;
    logic              h, l, u, b, r;
    logic              resume_evt;

    state_e             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic               stalled_q, stalled_d;
    logic [CNT_W-1:0]   collected_q, collected_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic               r_prev_q, r_prev_d;

    state_e             choice;
    logic               apply_rule;
    logic [STALL_W-1:0] stall_base;
    logic [STALL_W-1:0] stall_inc;
    logic               stall_trip;

    assign pads = {bus.resume, bus.barrier, bus.under, bus.left, bus.head};

    robo_sync #(
        .WIDTH  (SENS_W),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clock (clock),
        .reset (reset),
        .d     (pads),
        .q     (sens)
    );

    assign h          = sens[IDX_HEAD];
    assign l          = sens[IDX_LEFT];
    assign u          = sens[IDX_UNDER];
    assign b          = sens[IDX_BARRIER];
    assign r          = sens[IDX_RESUME];
    assign resume_evt = r & ~r_prev_q;

    // NOTE: every variable written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        stall_d     = stall_q;
        stalled_d   = stalled_q;
        collected_d = collected_q;
        r_prev_d    = r;
        fill_d      = (fill_q == FILL_DONE) ? fill_q : fill_q + FILL_W'(1);
        apply_rule  = 1'b0;
        choice      = decide(h, l, u, b);

        // Time spent driving forward wipes the stall history, even on the cycle we leave.
        stall_base = (state_q == AVANCANDO) ? '0 : stall_q;
        stall_inc  = stall_base + STALL_W'(1);
        stall_trip = (stall_inc == STALL_MAX);
        if (state_q == AVANCANDO) stall_d = '0;

        case (state_q)
            // Synchronisers read 0 (floor lost) until filled; wait for real pad values.
            INICIAL:   apply_rule = (fill_q == FILL_DONE);
            AVANCANDO: apply_rule = 1'b1;
            GIRANDO: begin
                if (!u)                 state_d = STANDBY;
                else if (timer_q != '0) timer_d = timer_q - TMR_W'(1);
                else                    apply_rule = 1'b1;
            end
            REMOVENDO: begin
                if (!u) begin
                    state_d = STANDBY;
                end else if (timer_q != '0) begin
                    timer_d = timer_q - TMR_W'(1);
                end else if (!b) begin
                    collected_d = (collected_q == CNT_MAX) ? collected_q
                                                           : collected_q + CNT_W'(1);
                    state_d     = AVANCANDO;
                end else if (stall_trip) begin
                    state_d   = STANDBY;
                    stalled_d = 1'b1;
                end else begin
                    timer_d = REMOVE_LOAD;
                    stall_d = stall_inc;
                end
            end
            STANDBY: begin
                if (resume_evt && u) begin
                    state_d   = INICIAL;
                    stalled_d = 1'b0;
                    stall_d   = '0;
                end
            end
            default: state_d = INICIAL;
        endcase

        if (apply_rule) begin
            case (choice)
                GIRANDO: begin
                    if (stall_trip) begin
                        state_d   = STANDBY;
                        stalled_d = 1'b1;
                    end else begin
                        state_d = GIRANDO;
                        timer_d = TURN_LOAD;
                        stall_d = stall_inc;
                    end
                end
                REMOVENDO: begin
                    state_d = REMOVENDO;
                    timer_d = REMOVE_LOAD;
                end
                default: state_d = choice;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= INICIAL;
            timer_q     <= '0;
            stall_q     <= '0;
            stalled_q   <= 1'b0;
            collected_q <= '0;
            fill_q      <= '0;
            r_prev_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            stall_q     <= stall_d;
            stalled_q   <= stalled_d;
            collected_q <= collected_d;
            fill_q      <= fill_d;
            r_prev_q    <= r_prev_d;
        end
    end

    assign bus.forward   = (state_q == AVANCANDO);
    assign bus.turn      = (state_q == GIRANDO);
    assign bus.remove    = (state_q == REMOVENDO);
    assign bus.stalled   = stalled_q;
    assign bus.collected = collected_q;

endmodule

// File: tb/tb_robo_coletor_param.sv
// Directed bench for robo_coletor_param: default instance for motion, watchdog
// and cliff scenarios; CNT_W=2 instance for saturation and async reset.
module tb_robo_coletor_param;

    logic clock = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   rm_cycles = 0;

    robo_coletor_param_if bus_a ();
    robo_coletor_param_if #(.CNT_W(2)) bus_b ();

    robo_coletor_param u_dut_a (
        .clock (clock),
        .reset (rst_a),
        .bus   (bus_a)
    );

    robo_coletor_param #(.CNT_W(2)) u_dut_b (
        .clock (clock),
        .reset (rst_b),
        .bus   (bus_b)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        bus_a.head = 1'b0; bus_a.left = 1'b1; bus_a.under = 1'b1;
        bus_a.barrier = 1'b0; bus_a.resume = 1'b0;
        bus_b.head = 1'b0; bus_b.left = 1'b1; bus_b.under = 1'b1;
        bus_b.barrier = 1'b0; bus_b.resume = 1'b0;
        tick(3);

        check("rst_forward",   bus_a.forward,   0);
        check("rst_turn",      bus_a.turn,      0);
        check("rst_remove",    bus_a.remove,    0);
        check("rst_stalled",   bus_a.stalled,   0);
        check("rst_collected", bus_a.collected, 0);

        // Wall following: forward appears on the third edge after release.
        rst_a = 1'b1;
        tick(2);
        check("wall_pre", {bus_a.forward, bus_a.turn, bus_a.remove}, 3'b000);
        for (int i = 0; i < 8; i++) begin
            tick(1);
            check($sformatf("wall_%0d", i), {bus_a.forward, bus_a.turn, bus_a.remove}, 3'b100);
        end

        // Obstacle: one-cycle head pulse gives exactly four turn cycles.
        bus_a.head = 1'b1;
        tick(1);
        bus_a.head = 1'b0;
        tick(1);
        check("obst_pre", {bus_a.forward, bus_a.turn, bus_a.remove}, 3'b100);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check($sformatf("obst_turn_%0d", i), {bus_a.forward, bus_a.turn, bus_a.remove}, 3'b010);
        end
        tick(1);
        check("obst_exit", {bus_a.forward, bus_a.turn, bus_a.remove}, 3'b100);

        // Removal success: barrier held 5 cycles, remove window of 8.
        bus_a.barrier = 1'b1;
        tick(2);
        check("rm_pre", bus_a.remove, 0);
        for (int i = 0; i < 8; i++) begin
            tick(1);
            if (i == 2) bus_a.barrier = 1'b0;
            check($sformatf("rm_win_%0d", i), {bus_a.forward, bus_a.turn, bus_a.remove}, 3'b001);
            check($sformatf("rm_cnt_%0d", i), bus_a.collected, 0);
        end
        tick(1);
        check("rm_exit", {bus_a.forward, bus_a.turn, bus_a.remove}, 3'b100);
        check("rm_collected", bus_a.collected, 1);

        // Watchdog: barrier stuck high, 16 windows of 8 cycles, then standby.
        rst_a = 1'b0;
        tick(2);
        rst_a = 1'b1;
        tick(3);
        check("wd_start", bus_a.forward, 1);
        bus_a.barrier = 1'b1;
        tick(2);
        rm_cycles = 0;
        for (int i = 0; i < 300; i++) begin
            tick(1);
            if (bus_a.remove) rm_cycles++;
            else if (rm_cycles > 0) break;
        end
        check("wd_remove_cycles", rm_cycles, 128);
        check("wd_stalled", bus_a.stalled, 1);
        check("wd_motors", {bus_a.forward, bus_a.turn, bus_a.remove}, 3'b000);
        check("wd_collected", bus_a.collected, 0);
        bus_a.barrier = 1'b0;
        tick(4);
        check("wd_hold_motors", {bus_a.forward, bus_a.turn, bus_a.remove}, 3'b000);
        check("wd_hold_stalled", bus_a.stalled, 1);
        bus_a.resume = 1'b1;
        tick(1);
        bus_a.resume = 1'b0;
        tick(2);
        check("wd_resume_motors", {bus_a.forward, bus_a.turn, bus_a.remove}, 3'b000);
        check("wd_resume_stalled", bus_a.stalled, 0);
        tick(1);
        check("wd_resume_fwd", bus_a.forward, 1);

        // Cliff during the second turn cycle.
        bus_a.head = 1'b1;
        tick(1);
        bus_a.head = 1'b0;
        tick(2);
        check("cliff_turn1", bus_a.turn, 1);
        tick(1);
        check("cliff_turn2", bus_a.turn, 1);
        bus_a.under = 1'b0;
        tick(2);
        check("cliff_turn4", bus_a.turn, 1);
        tick(1);
        check("cliff_drop", {bus_a.forward, bus_a.turn, bus_a.remove}, 3'b000);
        check("cliff_stalled", bus_a.stalled, 0);
        tick(3);
        check("cliff_hold", {bus_a.forward, bus_a.turn, bus_a.remove}, 3'b000);
        bus_a.resume = 1'b1;
        tick(1);
        bus_a.resume = 1'b0;
        tick(5);
        check("cliff_resume_ignored", {bus_a.forward, bus_a.turn, bus_a.remove}, 3'b000);
        bus_a.under = 1'b1;
        tick(6);
        check("cliff_no_pending", {bus_a.forward, bus_a.turn, bus_a.remove}, 3'b000);
        bus_a.resume = 1'b1;
        tick(1);
        bus_a.resume = 1'b0;
        tick(2);
        check("cliff_inicial", {bus_a.forward, bus_a.turn, bus_a.remove}, 3'b000);
        tick(1);
        check("cliff_forward", bus_a.forward, 1);
        check("cliff_collected_held", bus_a.collected, 0);

        // Saturation with a 2-bit counter, then async reset mid-remove.
        rst_b = 1'b1;
        tick(3);
        check("sat_start", bus_b.forward, 1);
        for (int k = 0; k < 4; k++) begin
            bus_b.barrier = 1'b1;
            tick(3);
            bus_b.barrier = 1'b0;
            tick(12);
            check($sformatf("sat_cnt_%0d", k), bus_b.collected, (k < 3) ? k + 1 : 3);
            check($sformatf("sat_fwd_%0d", k), bus_b.forward, 1);
        end
        bus_b.barrier = 1'b1;
        tick(3);
        bus_b.barrier = 1'b0;
        tick(2);
        check("arst_mid_remove", bus_b.remove, 1);
        check("arst_mid_cnt", bus_b.collected, 3);
        #2;
        rst_b = 1'b0;
        #1;
        check("arst_remove", bus_b.remove, 0);
        check("arst_collected", bus_b.collected, 0);
        check("arst_motors", {bus_b.forward, bus_b.turn}, 2'b00);
        tick(2);
        check("arst_held", {bus_b.forward, bus_b.turn, bus_b.remove, bus_b.stalled}, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
